pipe_fetch_unit: RTL and testbench
==================================

PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Interface
REQ-001 Parameter PC_W, 32, width of program counter and instruction address.
REQ-002 Parameter INST_W, 32, instruction width; a multiple of 8; INST_BYTES = INST_W/8 is the PC increment.
REQ-003 Parameter QDEPTH, 4, prefetch queue depth; a power of two, at least 2.
REQ-004 Parameter RESET_PC, 0, first fetch address after reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 imem_req  out  1  fetch request valid.
REQ-008 imem_addr  out  PC_W  fetch address, INST_BYTES-aligned.
REQ-009 imem_gnt  in  1  memory accepts the request this cycle.
REQ-010 imem_rdata  in  INST_W  instruction for the request granted in the previous cycle; fixed 1-cycle latency.
REQ-011 if_valid  out  1  queue head valid toward decode.
REQ-012 if_instr  out  INST_W  queue-head instruction.
REQ-013 if_pc  out  PC_W  queue-head instruction address.
REQ-014 id_ready  in  1  decode accepts the head (pop when if_valid & id_ready).
REQ-015 redirect_en  in  1  branch/flush redirect from a later stage.
REQ-016 redirect_pc  in  PC_W  redirect target; low log2(INST_BYTES) bits are ignored and treated as 0.
REQ-017 halt_req  in  1  request to stop fetching.
REQ-018 halted  out  1  HALT state reached and queue empty.
REQ-019 perf_redirects, perf_bubbles  out  32 each  performance counters (see Configuration).

Function
REQ-020 FSM states: BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-021 imem_req = (state==RUN) & !redirect_en & (count + inflight < QDEPTH); imem_addr = fetch_pc.
REQ-022 On imem_req & imem_gnt: fetch_pc <= fetch_pc + INST_BYTES, wrapping modulo 2^PC_W; inflight set for one cycle.
REQ-023 While imem_gnt=0, imem_req and imem_addr hold stable; no request is duplicated or skipped.
REQ-024 A response arriving in a cycle with inflight=1 and redirect_en=0 is pushed with its PC; latency from grant to if_valid is 2 cycles.
REQ-025 if_valid = !empty & !redirect_en; push and pop in the same cycle are both honoured; count never exceeds QDEPTH.
REQ-026 The credit rule in REQ-021 ensures the queue never overflows; no response is dropped except under REQ-027.
REQ-027 redirect_en: queue cleared, in-flight response discarded, fetch_pc <= redirect_pc, any pop that cycle is void, state <= RUN (also from HALT).
REQ-028 halt_req in RUN (no redirect): state <= HALT; issuing stops; the queue still drains to decode; halted=1 once empty.
REQ-029 Redirect has priority over halt_req in the same cycle; halt_req is re-sampled the next cycle.

Reset
REQ-030 rst: state=BOOT, fetch_pc=RESET_PC, queue empty, inflight=0, imem_req=0, if_valid=0, halted=0, counters 0.
REQ-031 rst asserted mid-operation aborts all state immediately; a response arriving after reset is ignored.

Configuration
REQ-032 Macro PIPE_FETCH_PERF_CNT_EN: when defined, perf_redirects counts redirect cycles and perf_bubbles counts RUN cycles with if_valid=0, both saturating at 2^32-1.
REQ-033 Without PIPE_FETCH_PERF_CNT_EN, both counter ports are tied to 0 and no counter flops exist.

Structure
REQ-034 Shared package fetch_pkg holds the fetch_state_t enum (BOOT, RUN, HALT) and the default constants.
REQ-035 Sub-module fetch_queue is a QDEPTH-entry FIFO of {pc, instr} with push, pop, clear, count and empty signals.

Verification
REQ-036 Reset release, gnt=1, id_ready=1, rdata=addr: imem_req first seen 2nd cycle, addr 0x0; if_pc 0x0, 0x4, 0x8 back-to-back.
REQ-037 id_ready=0, QDEPTH=4: exactly 4 grants (0x0-0xC), then imem_req=0; release gives in-order pops 0x0-0xC, then fetch resumes at 0x10.
REQ-038 Redirect to 0x100 with 3 entries queued and 1 in flight: no stale PC ever appears; next if_pc = 0x100.
REQ-039 imem_gnt=0 for 3 cycles at addr 0x8: addr held 0x8; each PC is delivered exactly once.
REQ-040 halt_req with 2 entries queued: halted=1 after 2 pops, imem_req=0; redirect to 0x40 resumes fetch with if_pc=0x40.
REQ-041 With the macro defined, 2 redirects give perf_redirects=2; without the macro, the port reads 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default configuration for the pipeline fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEF     = 32;
  localparam int INST_W_DEF   = 32;
  localparam int QDEPTH_DEF   = 4;
  localparam int RESET_PC_DEF = 0;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs; clear wins over push/pop in the same cycle.
module fetch_queue #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [INST_W-1:0] push_instr,
  input  logic              pop,
  input  logic              clear,
  output logic [PC_W-1:0]   head_pc,
  output logic [INST_W-1:0] head_instr,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [INST_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop, full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop) && !clear;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];
  assign count      = count_q;
  assign empty      = (count_q == '0);

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch unit: credit-based prefetch into a small queue, redirect and halt control.
// Optional performance counters are built when PIPE_FETCH_PERF_CNT_EN is defined.
module pipe_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter int              QDEPTH   = QDEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [INST_W-1:0] if_instr,
  output logic [PC_W-1:0]   if_pc,
  input  logic              id_ready,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_bubbles
);

  localparam int              INST_BYTES = INST_W / 8;
  localparam int              CNT_W      = $clog2(QDEPTH) + 1;
  localparam int              CW         = CNT_W + 1;
  localparam logic [PC_W-1:0] INST_STEP  = PC_W'(INST_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(INST_BYTES - 1);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  logic             q_push, q_pop, q_clear, q_empty;
  logic [CNT_W-1:0] q_count;
  logic             credit;

  fetch_queue #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .DEPTH  (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rdata),
    .pop        (q_pop),
    .clear      (q_clear),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (q_count),
    .empty      (q_empty)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;

    // Queued plus in-flight entries must leave room, so a response always has a slot.
    credit    = ({1'b0, q_count} + CW'(inflight_q)) < CW'(QDEPTH);
    imem_req  = (state_q == RUN) && !redirect_en && credit;
    imem_addr = fetch_pc_q;
    if_valid  = !q_empty && !redirect_en;
    q_pop     = if_valid && id_ready;
    q_push    = inflight_q && !redirect_en;
    q_clear   = redirect_en;
    // An outstanding response counts as not-yet-empty so halted cannot pulse early.
    halted    = (state_q == HALT) && q_empty && !inflight_q;

    if (imem_req && imem_gnt) begin
      fetch_pc_d    = fetch_pc_q + INST_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    if (redirect_en) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef PIPE_FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_bubbles_q,   perf_bubbles_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_bubbles_d   = perf_bubbles_q;
    if (redirect_en && (perf_redirects_q != '1))
      perf_redirects_d = perf_redirects_q + 32'd1;
    if ((state_q == RUN) && !if_valid && (perf_bubbles_q != '1))
      perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects_q <= '0;
      perf_bubbles_q   <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_bubbles_q   <= perf_bubbles_d;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_bubbles   = perf_bubbles_q;
`else
  assign perf_redirects = 32'd0;
  assign perf_bubbles   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed, table-driven bench for pipe_fetch_unit; memory returns the request address as data.
module tb_pipe_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic [31:0] perf_redirects;
  logic [31:0] perf_bubbles;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .perf_redirects (perf_redirects),
    .perf_bubbles   (perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle memory: data for a granted request is its own address.
  always @(posedge clk)
    imem_rdata <= (imem_req && imem_gnt) ? imem_addr : 32'hBAD0_BAD0;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, g, rdy, red, input logic [31:0] rpc, input logic h,
                   input logic er, input logic [31:0] ea, input logic ev,
                   input logic [31:0] ep, input logic eh);
    vec_t t;
    t.rst = r; t.gnt = g; t.rdy = rdy; t.redir = red; t.rpc = rpc; t.halt = h;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep; t.e_halted = eh;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, g, rdy, red, input logic [31:0] rpc, input logic h);
    @(negedge clk);
    rst = r; imem_gnt = g; id_ready = rdy; redirect_en = red; redirect_pc = rpc; halt_req = h;
    #1;
  endtask

  initial begin
    logic [31:0] exp_redir, exp_bub;
    rst = 1'b1; imem_gnt = 1'b0; id_ready = 1'b0; redirect_en = 1'b0;
    redirect_pc = '0; halt_req = 1'b0;

    // Back-to-back streaming after reset.
    v(1,1,1,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h4,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h8,  1,32'h0, 0);
    v(0,1,1,0,0,0, 1,32'hC,  1,32'h4, 0);
    v(0,1,1,0,0,0, 1,32'h10, 1,32'h8, 0);
    // Decode stalled: four grants fill the queue, then in-order drain and resume.
    v(1,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h4,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h8,  1,32'h0, 0);
    v(0,1,0,0,0,0, 1,32'hC,  1,32'h0, 0);
    v(0,1,0,0,0,0, 0,32'h0,  1,32'h0, 0);
    v(0,1,0,0,0,0, 0,32'h0,  1,32'h0, 0);
    v(0,1,1,0,0,0, 0,32'h0,  1,32'h0, 0);
    v(0,1,1,0,0,0, 1,32'h10, 1,32'h4, 0);
    v(0,1,1,0,0,0, 1,32'h14, 1,32'h8, 0);
    v(0,1,1,0,0,0, 1,32'h18, 1,32'hC, 0);
    v(0,1,1,0,0,0, 1,32'h1C, 1,32'h10,0);
    // Redirect (unaligned target) with 3 queued and 1 in flight.
    v(1,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h4,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h8,  1,32'h0, 0);
    v(0,1,0,0,0,0, 1,32'hC,  1,32'h0, 0);
    v(0,1,1,1,32'h102,0, 0,32'h0, 0,0, 0);
    v(0,1,1,0,0,0, 1,32'h100,0,0,     0);
    v(0,1,1,0,0,0, 1,32'h104,0,0,     0);
    v(0,1,1,0,0,0, 1,32'h108,1,32'h100,0);
    v(0,1,1,0,0,0, 1,32'h10C,1,32'h104,0);
    // Grant withheld for 3 cycles at 0x8.
    v(1,1,1,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h0,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h4,  0,0,     0);
    v(0,0,1,0,0,0, 1,32'h8,  1,32'h0, 0);
    v(0,0,1,0,0,0, 1,32'h8,  1,32'h4, 0);
    v(0,0,1,0,0,0, 1,32'h8,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h8,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'hC,  0,0,     0);
    v(0,1,1,0,0,0, 1,32'h10, 1,32'h8, 0);
    v(0,1,1,0,0,0, 1,32'h14, 1,32'hC, 0);
    // Halt with 2 queued, drain, then redirect out of HALT.
    v(1,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 0,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h0,  0,0,     0);
    v(0,1,0,0,0,0, 1,32'h4,  0,0,     0);
    v(0,0,0,0,0,1, 1,32'h8,  1,32'h0, 0);
    v(0,1,1,0,0,0, 0,32'h0,  1,32'h0, 0);
    v(0,1,1,0,0,0, 0,32'h0,  1,32'h4, 0);
    v(0,1,1,0,0,0, 0,32'h0,  0,0,     1);
    v(0,1,1,1,32'h40,0, 0,32'h0, 0,0, 1);
    v(0,1,1,0,0,0, 1,32'h40, 0,0,     0);
    v(0,1,1,0,0,0, 1,32'h44, 0,0,     0);
    v(0,1,1,0,0,0, 1,32'h48, 1,32'h40,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].gnt, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
        check($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_pc);
      end
      check($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halted));
    end

    // Two redirects, the first coinciding with halt_req: redirect wins, counters advance.
`ifdef PIPE_FETCH_PERF_CNT_EN
    exp_redir = 32'd2; exp_bub = 32'd2;
`else
    exp_redir = 32'd0; exp_bub = 32'd0;
`endif
    drive(1,0,1,0,0,0);
    check("perf_redirects reset", perf_redirects, 32'd0);
    check("perf_bubbles reset", perf_bubbles, 32'd0);
    drive(0,0,1,0,0,0);
    drive(0,0,1,1,32'h200,1);
    drive(0,1,1,1,32'h300,0);
    drive(0,1,1,0,0,0);
    check("redir beats halt req", 32'(imem_req), 32'd1);
    check("redir beats halt addr", imem_addr, 32'h300);
    check("redir beats halt halted", 32'(halted), 32'd0);
    check("perf_redirects", perf_redirects, exp_redir);
    check("perf_bubbles", perf_bubbles, exp_bub);

    // Asynchronous reset while a response is in flight: the late response is ignored.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst imem_req", 32'(imem_req), 32'd0);
    check("async rst if_valid", 32'(if_valid), 32'd0);
    check("async rst perf_redirects", perf_redirects, 32'd0);
    drive(0,1,1,0,0,0);
    check("post-rst boot req", 32'(imem_req), 32'd0);
    check("post-rst boot valid", 32'(if_valid), 32'd0);
    drive(0,1,1,0,0,0);
    check("post-rst first addr", imem_addr, 32'h0);
    check("post-rst stale valid", 32'(if_valid), 32'd0);
    drive(0,1,1,0,0,0);
    check("post-rst no stale push", 32'(if_valid), 32'd0);
    drive(0,1,1,0,0,0);
    check("post-rst head pc", if_pc, 32'h0);
    check("post-rst head valid", 32'(if_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
